// File: rtl/addr_lane_reg.sv
// ---------------------------------------------------------------------------
// addr_lane_reg
//   General-purpose address register for the register unit (J, PC, XY, M).
//   The register is LANES byte-wide lanes. A command is one of the following:
//     - load the whole register from the address bus
//     - load one or more lanes from the data bus
//     - increment the register
//   An accepted command is held in a pending register. It is committed only
//   after a relay-settle interval of SETTLE cycles. busy is high during that
//   interval. done pulses for one cycle after the commit.
//   The committed value drives the wired-OR address bus while sel is high.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst_n      in   asynchronous active-low reset
//   data_in    in   LANE_W  data-bus value used for lane loads
//   lane_load  in   LANES   per-lane load request (lane 0 = least significant)
//   addr_in    in   W       address-bus value used for whole-register loads
//   addr_load  in   1       whole-register load request (highest priority)
//   inc        in   1       increment request (lowest priority)
//   sel        in   1       drive request for the address bus
//   addr_out   out  W       committed content while sel=1, otherwise zero
//   led_sel    out  1       copy of sel for the panel LED
//   content    out  W       committed register value
//   busy       out  1       settle interval in progress
//   done       out  1       one-cycle pulse after a commit
//   carry      out  1       with done: the committed increment wrapped
//   overrun    out  1       one-cycle pulse: a command was dropped while busy
// ---------------------------------------------------------------------------
module addr_lane_reg #(
  parameter int LANE_W = 8,
  parameter int LANES  = 2,
  parameter int SETTLE = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANE_W-1:0]         data_in,
  input  logic [LANES-1:0]          lane_load,
  input  logic [LANES*LANE_W-1:0]   addr_in,
  input  logic                      addr_load,
  input  logic                      inc,
  input  logic                      sel,
  output logic [LANES*LANE_W-1:0]   addr_out,
  output logic                      led_sel,
  output logic [LANES*LANE_W-1:0]   content,
  output logic                      busy,
  output logic                      done,
  output logic                      carry,
  output logic                      overrun
);

  localparam int W     = LANES * LANE_W;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // The counter starts at SETTLE-1 and commits when it reaches zero.
  // This gives exactly SETTLE busy cycles after the accept edge.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SETTLE > 0) ? (SETTLE - 1) : 0);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_content;
  logic [W-1:0]     r_pending;
  logic             r_pend_carry;
  logic             r_done;
  logic             r_carry;
  logic             r_overrun;

  logic             w_any_cmd;
  logic [W-1:0]     w_next_pending;
  logic             w_next_carry;

  // Overwrite every lane flagged in mask with the same data byte.
  // Unflagged lanes keep their value from base.
  function automatic logic [W-1:0] lane_merge(
    input logic [W-1:0]      base,
    input logic [LANE_W-1:0] data,
    input logic [LANES-1:0]  mask
  );
    logic [W-1:0] merged;
    merged = base;
    for (int k = 0; k < LANES; k++) begin
      if (mask[k]) begin
        merged[k*LANE_W +: LANE_W] = data;
      end else begin
        merged[k*LANE_W +: LANE_W] = base[k*LANE_W +: LANE_W];
      end
    end
    return merged;
  endfunction

  assign w_any_cmd = addr_load | (|lane_load) | inc;

  // Candidate pending value, using the priority addr_load > lane_load > inc.
  always_comb begin
    w_next_pending = r_pending;
    w_next_carry   = 1'b0;
    if (addr_load) begin
      w_next_pending = addr_in;
      w_next_carry   = 1'b0;
    end else if (|lane_load) begin
      w_next_pending = lane_merge(r_content, data_in, lane_load);
      w_next_carry   = 1'b0;
    end else if (inc) begin
      w_next_pending = r_content + {{(W-1){1'b0}}, 1'b1};
      w_next_carry   = &r_content;
    end else begin
      w_next_pending = r_pending;
      w_next_carry   = 1'b0;
    end
  end

  // Command FSM: accept in IDLE, then count the settle interval and commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_content    <= {W{1'b0}};
      r_pending    <= {W{1'b0}};
      r_pend_carry <= 1'b0;
      r_done       <= 1'b0;
      r_carry      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_carry   <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_cmd) begin
            r_pending    <= w_next_pending;
            r_pend_carry <= w_next_carry;
            if (SETTLE == 0) begin
              // With no relay delay, the commit happens on the accept edge.
              r_content <= w_next_pending;
              r_done    <= 1'b1;
              r_carry   <= w_next_carry;
            end else begin
              r_state <= ST_SETTLE;
              r_cnt   <= CNT_LOAD;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          // Commands arriving mid-settle are discarded; only flag the loss.
          r_overrun <= w_any_cmd;
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_content <= r_pending;
            r_done    <= 1'b1;
            r_carry   <= r_pend_carry;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // The bus shows committed content only, never the pending value.
  assign addr_out = sel ? r_content : {W{1'b0}};
  assign led_sel  = sel;
  assign content  = r_content;
  assign busy     = (r_state == ST_SETTLE);
  assign done     = r_done;
  assign carry    = r_carry;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_addr_lane_reg.sv
// ---------------------------------------------------------------------------
// tb_addr_lane_reg
//   Scoreboard bench for addr_lane_reg.
//   Instance u_dut3 uses SETTLE=3. Instance u_dut0 uses SETTLE=0.
//   Each accepted command pushes its expected commit value and carry to a
//   queue. The entry is popped and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_addr_lane_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=3 instance signals
  logic        rst_n, addr_load, inc, sel;
  logic [7:0]  data_in;
  logic [1:0]  lane_load;
  logic [15:0] addr_in, addr_out, content;
  logic        led_sel, busy, done, carry, overrun;

  // SETTLE=0 instance signals
  logic        z_rst_n, z_addr_load, z_inc, z_sel;
  logic [7:0]  z_data_in;
  logic [1:0]  z_lane_load;
  logic [15:0] z_addr_in, z_addr_out, z_content;
  logic        z_led_sel, z_busy, z_done, z_carry, z_overrun;

  addr_lane_reg #(.LANE_W(8), .LANES(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .lane_load(lane_load),
    .addr_in(addr_in), .addr_load(addr_load), .inc(inc), .sel(sel),
    .addr_out(addr_out), .led_sel(led_sel), .content(content), .busy(busy),
    .done(done), .carry(carry), .overrun(overrun)
  );

  addr_lane_reg #(.LANE_W(8), .LANES(2), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(z_rst_n), .data_in(z_data_in), .lane_load(z_lane_load),
    .addr_in(z_addr_in), .addr_load(z_addr_load), .inc(z_inc), .sel(z_sel),
    .addr_out(z_addr_out), .led_sel(z_led_sel), .content(z_content), .busy(z_busy),
    .done(z_done), .carry(z_carry), .overrun(z_overrun)
  );

  typedef struct {
    logic [15:0] val;
    logic        c;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one command for a single edge and push the expected commit value.
  task automatic drive_cmd(input logic al, input logic [15:0] ai, input logic [1:0] ll,
                           input logic [7:0] di, input logic ic);
    exp_t e;
    @(negedge clk);
    addr_load = al; addr_in = ai; lane_load = ll; data_in = di; inc = ic;
    if (al) begin
      e.val = ai; e.c = 1'b0;
    end else if (ll != 2'b00) begin
      e.val = model;
      if (ll[0]) e.val[7:0]  = di;
      if (ll[1]) e.val[15:8] = di;
      e.c = 1'b0;
    end else begin
      e.val = model + 16'd1;
      e.c   = (model == 16'hFFFF);
    end
    sb_q.push_back(e);
    @(negedge clk);
    addr_load = 1'b0; lane_load = 2'b00; inc = 1'b0;
  endtask

  // Wait a bounded time for done, then pop the scoreboard and compare.
  task automatic wait_commit(input string tag, input int exp_busy);
    int   busy_cnt = 0;
    logic seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check_val({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_val({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check_val({tag, "_sb_depth"}, sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, "_content"}, {16'd0, content}, {16'd0, e.val});
      check_val({tag, "_carry"}, {31'd0, carry}, {31'd0, e.c});
      model = e.val;
    end
    @(negedge clk);
    check_val({tag, "_done_pulse_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic rst_done_seen;
    rst_n = 1'b0; z_rst_n = 1'b0;
    addr_load = 1'b0; inc = 1'b0; sel = 1'b0; data_in = 8'h00; lane_load = 2'b00; addr_in = 16'h0000;
    z_addr_load = 1'b0; z_inc = 1'b0; z_sel = 1'b0; z_data_in = 8'h00; z_lane_load = 2'b00;
    z_addr_in = 16'h0000;
    model = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; z_rst_n = 1'b1; sel = 1'b1;
    #1;
    check_val("rst_addr_out", {16'd0, addr_out}, 32'h0);
    check_val("rst_content", {16'd0, content}, 32'h0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_led_sel", {31'd0, led_sel}, 32'd1);

    // Lane loads, high lane first.
    drive_cmd(1'b0, 16'h0000, 2'b10, 8'h12, 1'b0);
    wait_commit("lane_hi", 3);
    drive_cmd(1'b0, 16'h0000, 2'b01, 8'h34, 1'b0);
    wait_commit("lane_lo", 3);
    check_val("bus_sel1", {16'd0, addr_out}, 32'h1234);
    sel = 1'b0; #1;
    check_val("bus_sel0", {16'd0, addr_out}, 32'h0000);
    check_val("led_sel0", {31'd0, led_sel}, 32'd0);
    sel = 1'b1;

    // Priority: addr_load beats both lanes and inc.
    drive_cmd(1'b1, 16'hBEEF, 2'b11, 8'h77, 1'b1);
    check_val("prio_no_overrun", {31'd0, overrun}, 32'd0);
    wait_commit("prio", 3);

    // Overrun: inc during busy is dropped; the bus keeps showing committed content.
    drive_cmd(1'b1, 16'h1357, 2'b00, 8'h00, 1'b0);
    check_val("settle_bus_committed", {16'd0, addr_out}, 32'hBEEF);
    inc = 1'b1;
    @(negedge clk);
    inc = 1'b0;
    check_val("overrun_pulse", {31'd0, overrun}, 32'd1);
    @(negedge clk);
    check_val("overrun_single", {31'd0, overrun}, 32'd0);
    wait_commit("overrun", 1);

    // Increment wrap and non-wrapping lane carry.
    drive_cmd(1'b1, 16'hFFFF, 2'b00, 8'h00, 1'b0);
    wait_commit("load_ffff", 3);
    drive_cmd(1'b0, 16'h0000, 2'b00, 8'h00, 1'b1);
    wait_commit("inc_wrap", 3);
    drive_cmd(1'b1, 16'h00FF, 2'b00, 8'h00, 1'b0);
    wait_commit("load_00ff", 3);
    drive_cmd(1'b0, 16'h0000, 2'b00, 8'h00, 1'b1);
    wait_commit("inc_00ff", 3);

    // Reset during settle aborts the operation without a commit.
    drive_cmd(1'b1, 16'hAAAA, 2'b00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_content", {16'd0, content}, 32'h0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_addr_out", {16'd0, addr_out}, 32'h0);
    sb_q.delete();
    model = 16'h0000;
    rst_done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) rst_done_seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) rst_done_seen = 1'b1;
    end
    check_val("midrst_no_done", {31'd0, rst_done_seen}, 32'd0);
    check_val("midrst_idle", {31'd0, busy}, 32'd0);
    check_val("midrst_content_after", {16'd0, content}, 32'h0);

    // SETTLE=0 instance: commit on the sampling edge, done in the next cycle.
    z_sel = 1'b1;
    @(negedge clk);
    z_lane_load = 2'b01; z_data_in = 8'h55;
    @(negedge clk);
    z_lane_load = 2'b00;
    check_val("s0_content", {16'd0, z_content}, 32'h0055);
    check_val("s0_done", {31'd0, z_done}, 32'd1);
    check_val("s0_busy", {31'd0, z_busy}, 32'd0);
    check_val("s0_carry", {31'd0, z_carry}, 32'd0);
    check_val("s0_addr_out", {16'd0, z_addr_out}, 32'h0055);
    @(negedge clk);
    check_val("s0_done_width", {31'd0, z_done}, 32'd0);
    check_val("s0_busy_after", {31'd0, z_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addr_lane_reg.md
# addr_lane_reg

Parametrised address-bus register built from LANES byte-wide lanes, each independently loadable from the data bus, and also loadable whole from the address bus. It supports an increment mode and drives its committed content onto the wired-OR address bus while selected. Loads are committed only after a programmable relay-settle interval, with a busy/done handshake. This is the general address register for the register unit (J, PC, XY, M style) and replaces fixed 16-bit, continuously assigned address registers.

## Interface
Parameters:
- LANE_W, 8, width of one lane (data bus width)
- LANES, 2, lane count; W = LANES*LANE_W is the register/address width
- SETTLE, 3, relay settle cycles between command accept and commit (0 allowed)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  LANE_W  data bus value for lane loads
- lane_load  in  LANES  per-lane load request; bit k targets bits [k*LANE_W +: LANE_W]; lane 0 is least significant
- addr_in  in  W  address bus value for whole-register load
- addr_load  in  1  whole-register load request
- inc  in  1  increment request (content + 1)
- sel  in  1  drive request for the address bus
- addr_out  out  W  content when sel=1, else all zeros (wired-OR bus)
- led_sel  out  1  equals sel (panel LED)
- content  out  W  committed register value
- busy  out  1  settle in progress
- done  out  1  one-cycle pulse after commit
- carry  out  1  with done; set when the committed increment wrapped
- overrun  out  1  one-cycle pulse when a command was dropped during busy

## Operation
- FSM states: IDLE, SETTLE.
- In IDLE, a command is any of addr_load, |lane_load, or inc.
- Priority: addr_load > lane_load > inc. Lower-priority requests in the same cycle are discarded silently.
- On accept, pending is captured:
  - addr_load: pending = addr_in.
  - lane_load: pending = content, with every flagged lane replaced by data_in. Multiple bits may be set; all flagged lanes take the same data_in.
  - inc: pending = content + 1, modulo 2^W. pend_carry = (content == all ones).
- If SETTLE=0, the commit happens at the accept edge. Otherwise the FSM goes to SETTLE, loads the counter with SETTLE-1, and decrements once per cycle. At counter 0 it commits and returns to IDLE.
- Commit: content <= pending. done pulses 1 for the following cycle. carry = pend_carry for an inc, else 0.
- Any command asserted while busy=1 is dropped. overrun pulses 1 in the next cycle. content and pending are unaffected.
- sel is independent of the FSM. addr_out shows committed content, never pending, including during SETTLE. When sel=0, addr_out = 0.
- The same cycle as the done pulse is IDLE, so a new command can be accepted then (back-to-back).

## Timing
- Reset values, all asynchronous on rst_n=0:
  - state IDLE
  - content 0, pending 0, counter 0
  - busy 0, done 0, carry 0, overrun 0
  - addr_out follows sel and content, so it reads 0
- Reset mid-SETTLE aborts the operation: no commit, no done.
- Command sampled at edge E0; busy=1 for exactly SETTLE cycles after E0.
- content changes at edge E_SETTLE. SETTLE=0 means it changes at E0.
- done, and carry if applicable, are high for exactly the cycle after E_SETTLE.
- addr_out and led_sel are combinational from sel and content; zero-cycle latency from sel.
- Increment wraps from all ones to 0 with carry=1. Lane loads never carry.

## Test plan
- Reset, then sel=1: addr_out=0x0000, content=0, busy=0, done=0.
- Lane sequence with SETTLE=3:
  - lane_load=2'b10, data_in=0x12 for one cycle: busy high 3 cycles, then content=0x1200, done 1 cycle.
  - Then lane_load=2'b01, data_in=0x34: content=0x1234.
  - sel=1 gives addr_out=0x1234; sel=0 gives 0x0000.
- Priority: addr_load=1 with addr_in=0xBEEF, plus lane_load=2'b11 and inc in the same cycle: content=0xBEEF, no overrun.
- Overrun: during busy, assert inc. overrun pulses once, and the original commit value lands unchanged.
- Increment wrap:
  - addr_load 0xFFFF, then inc: content=0x0000, done=1 and carry=1 in the same cycle.
  - inc from 0x00FF gives 0x0100 with carry=0.
- Reset mid-settle: addr_load 0xAAAA, then drop rst_n at busy cycle 2. content=0, no done, FSM in IDLE.
- SETTLE=0 build: lane_load=2'b01, data_in=0x55. content=0x0055 after the sampling edge, busy never high, done in the next cycle.
